// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin lock arbiter.
package rr_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Pointer position just past winner k in the search direction, modulo num.
  function automatic int ptr_after(input int k, input int num, input bit asc);
    if (asc) return (k == num - 1) ? 0 : k + 1;
    else     return (k == 0) ? num - 1 : k - 1;
  endfunction

endpackage

// File: rtl/sp_arbiter.sv
// Fixed-priority pick: lowest set bit wins when LSB_HIGH=1, highest set bit otherwise.
module sp_arbiter #(
  parameter int NUM      = 4,
  parameter int LSB_HIGH = 1
) (
  input  logic [NUM-1:0]         req_i,
  output logic [NUM-1:0]         gnt_o,
  output logic [$clog2(NUM)-1:0] id_o,
  output logic                   vld_o
);

  localparam int ID_W = $clog2(NUM);

  always_comb begin
    gnt_o = '0;
    id_o  = '0;
    if (LSB_HIGH != 0) begin
      for (int i = NUM - 1; i >= 0; i--) begin
        if (req_i[i]) begin
          gnt_o    = '0;
          gnt_o[i] = 1'b1;
          id_o     = ID_W'(i);
        end
      end
    end else begin
      for (int i = 0; i < NUM; i++) begin
        if (req_i[i]) begin
          gnt_o    = '0;
          gnt_o[i] = 1'b1;
          id_o     = ID_W'(i);
        end
      end
    end
  end

  assign vld_o = |req_i;

endmodule

// File: rtl/rr_lock_arbiter.sv
// Round-robin arbiter with owner lock; define RR_LOCK_ARB_HOLD_LIMIT_EN to cap
// a locked tenure at MAX_HOLD cycles.
//
//   state | meaning
//   IDLE  | no grant outstanding, gnt_o = 0
//   GRANT | exactly one owner, gnt_o one-hot
module rr_lock_arbiter
  import rr_arb_pkg::*;
#(
  parameter int NUM      = 4,
  parameter int LSB_HIGH = 1,
  parameter int MAX_HOLD = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM-1:0]         req_i,
  input  logic [NUM-1:0]         lock_i,
  output logic [NUM-1:0]         gnt_o,
  output logic [$clog2(NUM)-1:0] gnt_id_o,
  output logic                   gnt_vld_o
);

  localparam int ID_W = $clog2(NUM);
  localparam logic [ID_W-1:0] PTR_RST = (LSB_HIGH != 0) ? '0 : ID_W'(NUM - 1);

  arb_state_e      state_q, state_d;
  logic [NUM-1:0]  gnt_q, gnt_d;
  logic [ID_W-1:0] gnt_id_q, gnt_id_d;
  logic [ID_W-1:0] ptr_q, ptr_d;

  logic            hold_req, hold_ok;
  logic [NUM-1:0]  cand, mask, masked;
  logic [NUM-1:0]  m_gnt, a_gnt, win_oh;
  logic [ID_W-1:0] m_id, a_id, win_id;
  logic            m_vld, a_vld;

  assign hold_req = (state_q == GRANT) && (|(req_i & lock_i & gnt_q));

`ifdef RR_LOCK_ARB_HOLD_LIMIT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD);
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [NUM-1:0]    others;
  logic              force_rel;

  assign hold_ok   = hold_req && (hold_cnt_q != HOLD_W'(MAX_HOLD - 1));
  assign force_rel = hold_req && !hold_ok;
  assign others    = req_i & ~gnt_q;
  // A capped owner steps aside only if someone else is waiting.
  assign cand      = (force_rel && (|others)) ? others : req_i;
`else
  assign hold_ok = hold_req;
  assign cand    = req_i;
`endif

  always_comb begin
    mask = '0;
    for (int i = 0; i < NUM; i++) begin
      mask[i] = (LSB_HIGH != 0) ? (ID_W'(i) >= ptr_q) : (ID_W'(i) <= ptr_q);
    end
  end

  assign masked = cand & mask;

  sp_arbiter #(.NUM(NUM), .LSB_HIGH(LSB_HIGH)) u_pick_mask (
    .req_i (masked),
    .gnt_o (m_gnt),
    .id_o  (m_id),
    .vld_o (m_vld)
  );

  sp_arbiter #(.NUM(NUM), .LSB_HIGH(LSB_HIGH)) u_pick_any (
    .req_i (cand),
    .gnt_o (a_gnt),
    .id_o  (a_id),
    .vld_o (a_vld)
  );

  assign win_oh = m_vld ? m_gnt : a_gnt;
  assign win_id = m_vld ? m_id  : a_id;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      gnt_id_q   <= '0;
      ptr_q      <= PTR_RST;
`ifdef RR_LOCK_ARB_HOLD_LIMIT_EN
      hold_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      gnt_id_q   <= gnt_id_d;
      ptr_q      <= ptr_d;
`ifdef RR_LOCK_ARB_HOLD_LIMIT_EN
      hold_cnt_q <= hold_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d  = IDLE;
    gnt_d    = '0;
    gnt_id_d = '0;
    ptr_d    = ptr_q;
`ifdef RR_LOCK_ARB_HOLD_LIMIT_EN
    hold_cnt_d = '0;
`endif
    if (hold_ok) begin
      state_d  = GRANT;
      gnt_d    = gnt_q;
      gnt_id_d = gnt_id_q;
`ifdef RR_LOCK_ARB_HOLD_LIMIT_EN
      hold_cnt_d = hold_cnt_q + 1'b1;
`endif
    end else if (a_vld) begin
      state_d  = GRANT;
      gnt_d    = win_oh;
      gnt_id_d = win_id;
      ptr_d    = ID_W'(ptr_after(int'(win_id), NUM, LSB_HIGH != 0));
    end
  end

  always_comb begin
    gnt_o     = gnt_q;
    gnt_id_o  = gnt_id_q;
    gnt_vld_o = (state_q == GRANT);
  end

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Directed bench for rr_lock_arbiter (NUM=4, MAX_HOLD=4), ascending and descending instances.
module tb_rr_lock_arbiter;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [3:0] req_i, lock_i;
  logic [3:0] gnt_a, gnt_d;
  logic [1:0] id_a, id_d;
  logic       vld_a, vld_d;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  rr_lock_arbiter #(.NUM(4), .LSB_HIGH(1), .MAX_HOLD(4)) dut_asc (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (req_i),
    .lock_i    (lock_i),
    .gnt_o     (gnt_a),
    .gnt_id_o  (id_a),
    .gnt_vld_o (vld_a)
  );

  rr_lock_arbiter #(.NUM(4), .LSB_HIGH(0), .MAX_HOLD(4)) dut_desc (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (req_i),
    .lock_i    (lock_i),
    .gnt_o     (gnt_d),
    .gnt_id_o  (id_d),
    .gnt_vld_o (vld_d)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_i  = 1'b1;
    req_i  = '0;
    lock_i = '0;
    tick();
    rst_i = 1'b0;
  endtask

  initial begin
    logic [3:0] e4;
    rst_i  = 1'b1;
    req_i  = '0;
    lock_i = '0;
    tick();
    tick();
    chk("rst_gnt_a", gnt_a, 4'b0000);
    chk("rst_id_a",  id_a,  2'd0);
    chk("rst_vld_a", vld_a, 1'b0);
    chk("rst_gnt_d", gnt_d, 4'b0000);
    chk("rst_vld_d", vld_d, 1'b0);

    // all requesting, no locks: rotating grant in both directions
    rst_i = 1'b0;
    req_i = 4'b1111;
    chk("rr_pre_gnt", gnt_a, 4'b0000);
    for (int i = 0; i < 8; i++) begin
      tick();
      e4 = 4'b0001 << (i % 4);
      chk("rr_asc_gnt", gnt_a, e4);
      chk("rr_asc_id",  id_a,  i % 4);
      e4 = 4'b1000 >> (i % 4);
      chk("rr_desc_gnt", gnt_d, e4);
      chk("rr_desc_id",  id_d,  3 - (i % 4));
    end

    // locked owner 0 competing with requester 1
    do_reset();
    req_i  = 4'b0011;
    lock_i = 4'b0001;
`ifdef RR_LOCK_ARB_HOLD_LIMIT_EN
    for (int i = 0; i < 4; i++) begin tick(); chk("hold_first", gnt_a, 4'b0001); end
    tick();
    chk("hold_handoff", gnt_a, 4'b0010);
    chk("hold_handoff_id", id_a, 2'd1);
    for (int i = 0; i < 4; i++) begin tick(); chk("hold_second", gnt_a, 4'b0001); end
    tick();
    chk("hold_handoff2", gnt_a, 4'b0010);
`else
    for (int i = 0; i < 10; i++) begin tick(); chk("hold_forever", gnt_a, 4'b0001); end
`endif

    // capped owner with no competitor keeps the grant
    do_reset();
    req_i  = 4'b0001;
    lock_i = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("solo_lock_gnt", gnt_a, 4'b0001);
      chk("solo_lock_vld", vld_a, 1'b1);
    end

    // lock owner drops request: back-to-back handover
    do_reset();
    req_i  = 4'b0101;
    lock_i = 4'b0001;
    tick();
    chk("drop_own", gnt_a, 4'b0001);
    tick();
    chk("drop_held", gnt_a, 4'b0001);
    req_i = 4'b0100;
    tick();
    chk("drop_next_gnt", gnt_a, 4'b0100);
    chk("drop_next_vld", vld_a, 1'b1);
    chk("drop_next_id",  id_a,  2'd2);

    // reset during a lock by owner 2
    do_reset();
    req_i  = 4'b0100;
    lock_i = 4'b0100;
    tick();
    chk("lk2_gnt", gnt_a, 4'b0100);
    tick();
    chk("lk2_held", gnt_a, 4'b0100);
    rst_i = 1'b1;
    req_i = 4'b1010;
    tick();
    chk("midrst_gnt", gnt_a, 4'b0000);
    chk("midrst_id",  id_a,  2'd0);
    chk("midrst_vld", vld_a, 1'b0);
    rst_i = 1'b0;
    tick();
    chk("postrst_gnt", gnt_a, 4'b0010);
    chk("postrst_id",  id_a,  2'd1);

    // single steady requester then silence
    do_reset();
    req_i = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("single_gnt", gnt_a, 4'b0100);
      chk("single_id",  id_a,  2'd2);
    end
    req_i = 4'b0000;
    tick();
    chk("empty_gnt", gnt_a, 4'b0000);
    chk("empty_vld", vld_a, 1'b0);
    chk("empty_id",  id_a,  2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
